// File: rtl/axi_stream_router_n.sv
// Stream router: one config word sets a per-port beat count, then input beats are steered
// to NUM_PORTS registered output slots in ascending port order, optionally replaying.
module axi_stream_router_n #(
    parameter int unsigned DATA_W    = 22,
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned CFG_W     = NUM_PORTS * CNT_W + 1,
    parameter int unsigned PW        = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_tvalid,
    input  logic [DATA_W-1:0]             s_tdata,
    output logic                          s_tready,
    input  logic                          config_tvalid,
    input  logic [CFG_W-1:0]              config_tdata,
    output logic                          config_tready,
    output logic [NUM_PORTS-1:0]          m_tvalid,
    output logic [NUM_PORTS*DATA_W-1:0]   m_tdata,
    output logic [NUM_PORTS-1:0]          m_tlast,
    input  logic [NUM_PORTS-1:0]          m_tready,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {StIdle, StCfg, StRoute, StDrain} state_e;

    state_e                      state_q, state_d;
    logic [NUM_PORTS*CNT_W-1:0]  counts_q, counts_d;
    logic                        rpt_q, rpt_d;
    logic [PW-1:0]               port_q, port_d;
    logic [CNT_W-1:0]            rem_q, rem_d;
    logic [NUM_PORTS-1:0]        vld_q, vld_d, last_q, last_d;
    logic [NUM_PORTS*DATA_W-1:0] data_q, data_d;

    logic [CNT_W-1:0] cnt [NUM_PORTS];
    logic [PW-1:0]    port_nxt;
    logic             cfg_hs, s_hs, last_port, rem_zero, advance, drained;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
        assign cnt[g] = counts_q[g*CNT_W +: CNT_W];
    end

    assign cfg_hs    = config_tvalid & config_tready;
    assign s_hs      = s_tvalid & s_tready;
    assign port_nxt  = port_q + 1'b1;
    assign last_port = (port_q == PW'(NUM_PORTS - 1));
    assign rem_zero  = (rem_q == '0);
    assign drained   = (vld_q == '0);
    // Port advances on its last accepted beat, or immediately when its count is zero.
    assign advance   = (state_q == StRoute) && (rem_zero || (s_hs && rem_q == CNT_W'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StCfg;
            StCfg:   if (cfg_hs) state_d = StRoute;
            StRoute: if (advance && last_port) state_d = StDrain;
            StDrain: if (drained) state_d = rpt_q ? StRoute : StCfg;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        config_tready = (state_q == StCfg);
        s_tready      = (state_q == StRoute) && !rem_zero &&
                        (!vld_q[port_q] || m_tready[port_q]);
        busy          = (state_q == StRoute) || (state_q == StDrain);
        done          = (state_q == StDrain) && drained;
    end

    always_comb begin
        counts_d = counts_q;
        rpt_d    = rpt_q;
        port_d   = port_q;
        rem_d    = rem_q;
        if (cfg_hs) begin
            counts_d = config_tdata[CFG_W-2:0];
            rpt_d    = config_tdata[CFG_W-1];
            port_d   = '0;
            rem_d    = config_tdata[CNT_W-1:0];
        end else if (advance) begin
            rem_d = '0;
            if (!last_port) begin
                port_d = port_nxt;
                rem_d  = cnt[port_nxt];
            end
        end else if (s_hs) begin
            rem_d = rem_q - 1'b1;
        end else if (state_q == StDrain && drained && rpt_q) begin
            port_d = '0;
            rem_d  = cnt[0];
        end
    end

    // A load into a slot takes priority over its drain, keeping valid high.
    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        data_d = data_q;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (s_hs && port_q == PW'(i)) begin
                vld_d[i]                  = 1'b1;
                last_d[i]                 = (rem_q == CNT_W'(1));
                data_d[i*DATA_W +: DATA_W] = s_tdata;
            end else if (m_tready[i]) begin
                vld_d[i]  = 1'b0;
                last_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counts_q <= '0;
            rpt_q    <= 1'b0;
            port_q   <= '0;
            rem_q    <= '0;
            vld_q    <= '0;
            last_q   <= '0;
            data_q   <= '0;
        end else begin
            counts_q <= counts_d;
            rpt_q    <= rpt_d;
            port_q   <= port_d;
            rem_q    <= rem_d;
            vld_q    <= vld_d;
            last_q   <= last_d;
            data_q   <= data_d;
        end
    end

    assign m_tvalid = vld_q;
    assign m_tlast  = last_q;
    assign m_tdata  = data_q;

endmodule

// File: tb/tb_axi_stream_router_n.sv
// Directed-plus-random bench for axi_stream_router_n with a per-port scoreboard model.
module tb_axi_stream_router_n;

    localparam int DW   = 22;
    localparam int NP   = 3;
    localparam int CW   = 8;
    localparam int CFGW = NP * CW + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_tvalid;
    logic [DW-1:0]     s_tdata;
    logic              s_tready;
    logic              config_tvalid;
    logic [CFGW-1:0]   config_tdata;
    logic              config_tready;
    logic [NP-1:0]     m_tvalid;
    logic [NP*DW-1:0]  m_tdata;
    logic [NP-1:0]     m_tlast;
    logic [NP-1:0]     m_tready;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    axi_stream_router_n #(
        .DATA_W    (DW),
        .NUM_PORTS (NP),
        .CNT_W     (CW)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_tvalid      (s_tvalid),
        .s_tdata       (s_tdata),
        .s_tready      (s_tready),
        .config_tvalid (config_tvalid),
        .config_tdata  (config_tdata),
        .config_tready (config_tready),
        .m_tvalid      (m_tvalid),
        .m_tdata       (m_tdata),
        .m_tlast       (m_tlast),
        .m_tready      (m_tready),
        .busy          (busy),
        .done          (done)
    );

    int n_pass = 0, n_chk = 0, n_fail = 0;

    // Reference model: schedule from the config word, expected beats per port.
    logic [DW:0]   exp_q [NP][$];
    int            sched [NP];
    int            sched_tot = 0;
    bit            sched_rpt = 0;
    int            k = 0;
    int            cyc = 0;
    int            cfg_cyc = 0, first_acc = -1, last_acc = 0, done_cyc = 0, done_cnt = 0;
    bit            hold_prev [NP];
    logic [DW-1:0] data_prev [NP];
    logic          last_prev [NP];
    bit            hs_s = 0, hs_c = 0, prev_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Port and last flag of the kk-th accepted beat under the latched schedule.
    function automatic int port_of(input int kk, output bit lst);
        int r;
        lst = 0;
        r   = kk % sched_tot;
        for (int i = 0; i < NP; i++) begin
            if (r < sched[i]) begin
                lst = (r == sched[i] - 1);
                return i;
            end
            r -= sched[i];
        end
        return 0;
    endfunction

    task automatic step();
        logic [DW:0] e;
        bit          pending, l;
        int          p;
        @(negedge clk);
        cyc++;
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                if (hold_prev[i]) begin
                    chk("hold_valid", 64'(m_tvalid[i]), 64'(1));
                    chk("hold_data", 64'(m_tdata[i*DW +: DW]), 64'(data_prev[i]));
                    chk("hold_last", 64'(m_tlast[i]), 64'(last_prev[i]));
                end
                if (m_tvalid[i] && m_tready[i]) begin
                    chk("beat_expected", 64'(exp_q[i].size() != 0), 64'(1));
                    if (exp_q[i].size() != 0) begin
                        e = exp_q[i].pop_front();
                        chk("tdata", 64'(m_tdata[i*DW +: DW]), 64'(e[DW-1:0]));
                        chk("tlast", 64'(m_tlast[i]), 64'(e[DW]));
                    end
                end
                hold_prev[i] = m_tvalid[i] && !m_tready[i];
                data_prev[i] = m_tdata[i*DW +: DW];
                last_prev[i] = m_tlast[i];
            end
            pending = sched_rpt ? (sched_tot > 0) : (k < sched_tot);
            if (!pending) begin
                chk("s_tready_idle", 64'(s_tready), 64'(0));
            end else begin
                p = port_of(k, l);
                if (m_tvalid[p] && !m_tready[p]) chk("s_tready_full", 64'(s_tready), 64'(0));
            end
            hs_s = s_tvalid && s_tready;
            if (hs_s) begin
                chk("accept_allowed", 64'(pending), 64'(1));
                if (pending) begin
                    p = port_of(k, l);
                    exp_q[p].push_back({l, s_tdata});
                    k++;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
            end
            hs_c = config_tvalid && config_tready;
            if (hs_c) begin
                sched_tot = 0;
                for (int i = 0; i < NP; i++) begin
                    sched[i]   = int'(config_tdata[i*CW +: CW]);
                    sched_tot += sched[i];
                end
                sched_rpt = config_tdata[CFGW-1];
                k         = 0;
                cfg_cyc   = cyc;
                first_acc = -1;
            end
            if (done) begin
                chk("done_single_cycle", 64'(prev_done), 64'(0));
                done_cnt++;
                done_cyc = cyc;
            end
            prev_done = done;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_send(input int c0, input int c1, input int c2, input bit rpt);
        config_tdata  = {rpt, CW'(c2), CW'(c1), CW'(c0)};
        config_tvalid = 1'b1;
        hs_c          = 0;
        for (int t = 0; t < 20 && !hs_c; t++) step();
        chk("cfg_handshake", 64'(hs_c), 64'(1));
        config_tvalid = 1'b0;
        config_tdata  = CFGW'($urandom);
    endtask

    // vmode: 1 = continuous valid; rmode: 0 = ready high, 1 = random, 2 = port0 stalled.
    task automatic run(input int n_done, input int tmo, input int vmode, input int rmode,
                       input bit seqdata);
        int dn0  = done_cnt;
        int c    = 0;
        int dval = 1;
        bit cfg_rdy_seen = 0;
        s_tvalid = 1'b0;
        while (done_cnt - dn0 < n_done && c < tmo) begin
            if (config_tready) cfg_rdy_seen = 1;
            if (!s_tvalid || hs_s) begin
                s_tvalid = (vmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                if (seqdata) begin
                    s_tdata = DW'(dval);
                    dval++;
                end else begin
                    s_tdata = DW'($urandom);
                end
            end
            case (rmode)
                0:       m_tready = '1;
                1:       m_tready = NP'($urandom);
                default: m_tready = (c >= 2 && c < 6) ? 3'b110 : 3'b111;
            endcase
            step();
            c++;
        end
        chk("run_done_in_time", 64'(done_cnt - dn0), 64'(n_done));
        chk("config_tready_low_in_run", 64'(cfg_rdy_seen), 64'(0));
        s_tvalid = 1'b0;
        m_tready = '1;
    endtask

    task automatic end_checks(input int exp_beats);
        chk("beats_accepted", 64'(k), 64'(exp_beats));
        for (int i = 0; i < NP; i++) chk("queue_drained", 64'(exp_q[i].size()), 64'(0));
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_m_tlast", 64'(m_tlast), 64'(0));
        chk("rst_m_tdata", 64'(m_tdata), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(0));
        chk("rst_config_tready", 64'(config_tready), 64'(0));
        chk("rst_busy_done", 64'({busy, done}), 64'(0));
        for (int i = 0; i < NP; i++) begin
            exp_q[i].delete();
            hold_prev[i] = 0;
        end
        sched_tot = 0;
        sched_rpt = 0;
        k         = 0;
        hs_s      = 0;
        prev_done = 0;
        s_tvalid  = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("idle_no_cfg_ready", 64'(config_tready), 64'(0));
        @(posedge clk);
        #1;
        chk("cfg_ready_after_idle", 64'(config_tready), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2;
        rst           = 1'b0;
        s_tvalid      = 1'b0;
        s_tdata       = '0;
        config_tvalid = 1'b0;
        config_tdata  = '0;
        m_tready      = '1;
        for (int i = 0; i < NP; i++) hold_prev[i] = 0;
        #2;
        chk("reset_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("reset_m_tdata", 64'(m_tdata), 64'(0));
        chk("reset_ctrl", 64'({s_tready, config_tready, busy, done}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("idle_cycle", 64'(config_tready), 64'(0));
        @(posedge clk);
        #1;
        chk("cfg_state", 64'({config_tready, busy}), 64'(2'b10));

        // Counts {2,3,1}, continuous data 1..6.
        cfg_send(2, 3, 1, 0);
        chk("busy_in_route", 64'(busy), 64'(1));
        run(1, 50, 1, 0, 1);
        end_checks(6);
        chk("first_beat_latency", 64'(first_acc - cfg_cyc), 64'(1));
        chk("no_bubble", 64'(last_acc - first_acc), 64'(5));
        chk("done_timing", 64'(done_cyc - last_acc), 64'(2));
        chk("back_to_cfg", 64'({config_tready, busy, done}), 64'(3'b100));

        // Counts {0,2,0}: skip cycles around port 1.
        cfg_send(0, 2, 0, 0);
        run(1, 50, 1, 0, 0);
        end_checks(2);
        chk("skip_first", 64'(first_acc - cfg_cyc), 64'(2));
        chk("skip_burst", 64'(last_acc - first_acc), 64'(1));
        chk("skip_done", 64'(done_cyc - last_acc), 64'(2));

        // All-zero config.
        cfg_send(0, 0, 0, 0);
        run(1, 50, 1, 0, 0);
        end_checks(0);
        chk("zero_cfg_done", 64'(done_cyc - cfg_cyc), 64'(4));

        // Port 0 backpressure for four cycles.
        cfg_send(3, 1, 1, 0);
        run(1, 60, 1, 2, 0);
        end_checks(5);

        // Repeat mode: two schedules from one config word.
        cfg_send(1, 1, 1, 1);
        run(2, 60, 1, 0, 0);
        end_checks(6);
        do_reset();

        // Reset in the middle of port 1's burst.
        cfg_send(2, 4, 2, 0);
        s_tvalid = 1'b1;
        m_tready = '1;
        for (int t = 0; t < 30 && k < 4; t++) begin
            if (hs_s) s_tdata = DW'($urandom);
            step();
        end
        chk("reached_port1", 64'(k), 64'(4));
        do_reset();

        // Maximum count, random valid/ready.
        cfg_send(255, 0, 0, 0);
        run(1, 3000, 0, 1, 0);
        end_checks(255);

        // Random schedules.
        for (int r = 0; r < 4; r++) begin
            c0 = $urandom_range(0, 6);
            c1 = $urandom_range(0, 6);
            c2 = $urandom_range(0, 6);
            cfg_send(c0, c1, c2, 0);
            run(1, 400, 0, 1, 0);
            end_checks(c0 + c1 + c2);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_stream_router_n.md
Name: axi_stream_router_n

Overview:
Parametrised successor of the fixed 3-port stream router. Accepts one configuration word holding a per-port beat count, then routes input beats to NUM_PORTS outputs in ascending port order (count[0] beats to port 0, then count[1] to port 1, and so on).
Each output has its own registered slot with full AXI-Stream backpressure, and TLAST marks the last beat of each port's burst. An optional repeat mode replays the latched schedule without a new config word. Sits between a single stream source and NUM_PORTS downstream consumers.

Parameters:
DATA_W, 22, stream data width
NUM_PORTS, 3, number of output ports (2..16)
CNT_W, 8, width of each per-port beat count
CFG_W, NUM_PORTS*CNT_W+1, derived config width; not to be overridden
PW, $clog2(NUM_PORTS), derived port-index width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
s_tvalid  in  1  input beat valid
s_tdata  in  DATA_W  input beat data
s_tready  out  1  input beat accepted when s_tvalid&s_tready
config_tvalid  in  1  config word valid
config_tdata  in  CFG_W  bits [i*CNT_W +: CNT_W] = count for port i; bit [CFG_W-1] = repeat
config_tready  out  1  config accepted when config_tvalid&config_tready
m_tvalid  out  NUM_PORTS  per-port output valid
m_tdata  out  NUM_PORTS*DATA_W  port i data at [i*DATA_W +: DATA_W]
m_tlast  out  NUM_PORTS  per-port last beat of burst
m_tready  in  NUM_PORTS  per-port downstream ready
busy  out  1  high in ROUTE and DRAIN
done  out  1  one-cycle pulse when a schedule completes and all slots have drained

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all m_tvalid, m_tlast, m_tdata = 0; counts, cur_port and remaining = 0.
  - s_tready, config_tready, busy and done = 0.
  - Reset mid-burst discards all in-flight beats; no partial completion.
- States:
  - IDLE: one cycle after reset release, then CFG.
  - CFG: config_tready=1, s_tready=0. On config handshake: latch counts and repeat; cur_port=0; remaining=count[0]; go to ROUTE.
  - ROUTE: s_tready = (remaining!=0) && (!m_tvalid[cur_port] || m_tready[cur_port]). Combinational; no dependence on s_tvalid.
  - DRAIN: s_tready=0. When all m_tvalid=0: pulse done for one cycle. Then, if repeat=1: go to ROUTE with cur_port=0 and remaining=count[0]. If repeat=0: go to CFG.
- Beat acceptance in ROUTE (s handshake):
  - Slot cur_port loads s_tdata next edge; m_tvalid[cur_port]=1; m_tlast[cur_port] = (remaining==1); remaining decrements.
  - Latency is one cycle, s handshake to m_tvalid. Throughput is 1 beat/cycle while m_tready is high.
- Port advance: occurs on the edge where remaining becomes 0 through the last-beat accept, or when remaining==0 on entry (zero count, one skip cycle with s_tready=0).
  - If cur_port < NUM_PORTS-1: cur_port+1; remaining = count[cur_port+1]. No bubble when the next count is nonzero.
  - If cur_port = NUM_PORTS-1: go to DRAIN.
- Output slot behaviour:
  - An output slot keeps m_tvalid, m_tdata and m_tlast stable until m_tready. On m_tready with no new load: m_tvalid=0, m_tlast=0, m_tdata holds.
  - Simultaneous drain and load of the same slot: the new beat wins and valid stays 1.
  - Previous ports' slots may still be draining while the next port is routed; each slot drains independently.
- Config timing: config_tvalid is ignored outside CFG. config_tdata is sampled only on handshake.
- Boundary cases:
  - Count of 0 skips the port.
  - An all-zero config reaches DRAIN after NUM_PORTS skip cycles and pulses done.
  - Count of 2^CNT_W-1 is legal. remaining is CNT_W bits with no wrap.
- busy=1 in ROUTE and DRAIN only.

Test Plan:
- NUM_PORTS=3, config counts {2,3,1}, repeat=0, all m_tready=1, continuous s_tvalid with data 1..6. Required: port0 gets 1,2; port1 gets 3,4,5; port2 gets 6. m_tlast on 2, 5 and 6. No bubble between ports. done pulses one cycle after beat 6 drains. Returns to CFG.
- Counts {0,2,0}. Required: one skip cycle, then port1 gets 2 beats, then one skip cycle. s_tready=0 during skip cycles. done pulses.
- m_tready[0] held low for 4 cycles while routing count 3 to port 0. Required: m_tvalid[0] and m_tdata[0] stay stable. s_tready=0 while slot 0 is full. No beat is lost or duplicated.
- repeat=1, counts {1,1,1}. Required: two consecutive schedules with no second config handshake. config_tready stays 0 and done pulses twice.
- Assert rst=0 mid-way through port1's burst. Required: all outputs 0 in the same cycle (async). After release: one IDLE cycle, then config_tready=1.
- Counts {255,0,0} with CNT_W=8. Required: exactly 255 beats to port 0, m_tlast only on beat 255, no count wrap.
